// File: rtl/gravador_pkg.sv
// Shared types and uio bit positions for the gravador sample recorder.
package gravador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_e;

  // uio_in control bits
  localparam int unsigned UIO_REC_REQ  = 0;
  localparam int unsigned UIO_PLAY_REQ = 1;
  localparam int unsigned UIO_LOOP_EN  = 2;
  localparam int unsigned UIO_CH_SEL   = 3;

  // uio_out status bits
  localparam int unsigned UIO_FULL      = 4;
  localparam int unsigned UIO_EMPTY     = 5;
  localparam int unsigned UIO_RECORDING = 6;
  localparam int unsigned UIO_PLAYING   = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  // Status payload driven on uio_out, MSB first
  typedef struct packed {
    logic       playing;
    logic       recording;
    logic       empty;
    logic       full;
    logic [3:0] rsvd;
  } status_t;

endpackage

// File: rtl/gravador_mem.sv
// Sample storage: NCH x DEPTH x SAMPLE_W, one sync write port, one registered read port.
module gravador_mem
  import gravador_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NCH      = 2,
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic                     i_wr_ch,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [SAMPLE_W-1:0]      i_wr_data,
  input  logic                     i_rd_en,
  input  logic                     i_rd_ch,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [SAMPLE_W-1:0]      o_rd_data
);

  logic [SAMPLE_W-1:0] r_mem [NCH][DEPTH];
  logic [SAMPLE_W-1:0] r_rd_data;

  // Array itself is never reset; contents are meaningless until rewritten
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_ch][i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_ch][i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tt_um_gravador_param.sv
// Multi-channel sample recorder/player. Define GRAVADOR_LOOP_EN to enable
// looped playback via uio_in[2]; otherwise playback always stops at the end.
module tt_um_gravador_param
  import gravador_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NCH      = 2,
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_e        r_state, w_state_nxt;
  logic          r_ch, w_ch_nxt;
  logic [AW-1:0] r_wptr, w_wptr_nxt;
  logic [AW-1:0] r_rptr, w_rptr_nxt;
  logic [CW-1:0] r_count [NCH];
  logic [CW-1:0] w_count_nxt [NCH];
  logic          r_rec_hold, w_rec_hold_nxt;
  logic          r_play_hold, w_play_hold_nxt;
  status_t       r_status, w_status_nxt;

  logic                w_rec_req, w_play_req, w_loop, w_ch_sel;
  logic                w_rec_go, w_play_go, w_last_wr, w_last_rd;
  logic [CW-1:0]       w_cnt_cur;
  logic                w_wr_en, w_wr_ch, w_rd_en;
  logic [AW-1:0]       w_wr_addr;
  logic [SAMPLE_W-1:0] w_rd_data;
  logic                w_unused;

  assign w_rec_req  = uio_in[UIO_REC_REQ];
  assign w_play_req = uio_in[UIO_PLAY_REQ];
  assign w_ch_sel   = (NCH > 1) ? uio_in[UIO_CH_SEL] : 1'b0;
`ifdef GRAVADOR_LOOP_EN
  assign w_loop     = uio_in[UIO_LOOP_EN];
`else
  assign w_loop     = 1'b0;
`endif
  assign w_unused   = ^{uio_in, ui_in};

  // A request that self-terminated must be released before it can re-arm
  assign w_rec_go  = w_rec_req & ~r_rec_hold;
  assign w_play_go = w_play_req & ~r_play_hold & (r_count[w_ch_sel] != '0);
  assign w_cnt_cur = r_count[r_ch];
  assign w_last_wr = (w_cnt_cur == CW'(DEPTH - 1));
  assign w_last_rd = (r_rptr == AW'(w_cnt_cur - CW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : p_next_state
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rec_go)       w_state_nxt = ST_RECORD;
        else if (w_play_go) w_state_nxt = ST_PLAY;
      end
      ST_RECORD: begin
        if (!w_rec_req || w_last_wr) w_state_nxt = ST_IDLE;
      end
      ST_PLAY: begin
        if (!w_play_req || (w_last_rd && !w_loop)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin : p_outputs
    w_wr_en         = 1'b0;
    w_wr_ch         = r_ch;
    w_wr_addr       = r_wptr;
    w_rd_en         = 1'b0;
    w_ch_nxt        = r_ch;
    w_wptr_nxt      = r_wptr;
    w_rptr_nxt      = r_rptr;
    w_count_nxt     = r_count;
    w_rec_hold_nxt  = r_rec_hold & w_rec_req;
    w_play_hold_nxt = r_play_hold & w_play_req;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rec_go) begin
          // First sample lands on the entry edge
          w_wr_en               = 1'b1;
          w_wr_ch               = w_ch_sel;
          w_wr_addr             = '0;
          w_ch_nxt              = w_ch_sel;
          w_wptr_nxt            = AW'(1);
          w_count_nxt[w_ch_sel] = CW'(1);
        end else if (w_play_go) begin
          w_ch_nxt   = w_ch_sel;
          w_rptr_nxt = '0;
        end
      end
      ST_RECORD: begin
        if (w_rec_req) begin
          w_wr_en           = 1'b1;
          w_wptr_nxt        = r_wptr + AW'(1);
          w_count_nxt[r_ch] = w_cnt_cur + CW'(1);
          if (w_last_wr) w_rec_hold_nxt = 1'b1;
        end
      end
      ST_PLAY: begin
        if (w_play_req) begin
          w_rd_en = 1'b1;
          if (w_last_rd) begin
            w_rptr_nxt = '0;
            if (!w_loop) w_play_hold_nxt = 1'b1;
          end else begin
            w_rptr_nxt = r_rptr + AW'(1);
          end
        end
      end
      default: ;
    endcase
    w_status_nxt           = '0;
    w_status_nxt.full      = (w_count_nxt[w_ch_sel] == CW'(DEPTH));
    w_status_nxt.empty     = (w_count_nxt[w_ch_sel] == '0);
    w_status_nxt.recording = (w_state_nxt == ST_RECORD);
    w_status_nxt.playing   = (w_state_nxt == ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch        <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_rec_hold  <= 1'b0;
      r_play_hold <= 1'b0;
      r_status    <= '0;
      for (int i = 0; i < NCH; i++) r_count[i] <= '0;
    end else if (ena) begin
      r_ch        <= w_ch_nxt;
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_rec_hold  <= w_rec_hold_nxt;
      r_play_hold <= w_play_hold_nxt;
      r_status    <= w_status_nxt;
      r_count     <= w_count_nxt;
    end
  end

  gravador_mem #(
    .DEPTH   (DEPTH),
    .NCH     (NCH),
    .SAMPLE_W(SAMPLE_W)
  ) u_mem (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wr_en  (ena & w_wr_en),
    .i_wr_ch  (w_wr_ch),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(ui_in[SAMPLE_W-1:0]),
    .i_rd_en  (ena & w_rd_en),
    .i_rd_ch  (r_ch),
    .i_rd_addr(r_rptr),
    .o_rd_data(w_rd_data)
  );

  assign uo_out  = 8'(w_rd_data);
  assign uio_out = r_status;
  assign uio_oe  = UIO_OE_MASK;

endmodule

// File: doc/tt_um_gravador_param.md
TT_UM_GRAVADOR_PARAM -- requirements
Module: tt_um_gravador_param

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning samples per channel (power of two, 4..64).
REQ-002 The block SHALL have parameter NCH, default 2, meaning recording channels (1 or 2).
REQ-003 The block SHALL have parameter SAMPLE_W, default 8, meaning stored bits per sample (1..8); stored from ui_in[SAMPLE_W-1:0], upper uo_out bits read 0.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  design enable; low freezes all state.
REQ-007 ui_in  input  8  sample data to record.
REQ-008 uo_out  output  8  registered playback sample.
REQ-009 uio_in  input  8  control: [0] rec_req, [1] play_req, [2] loop_en, [3] ch_sel (ignored when NCH=1), [7:4] unused.
REQ-010 uio_out  output  8  status: [4] full(sel ch), [5] empty(sel ch), [6] recording, [7] playing; [3:0] = 0.
REQ-011 uio_oe  output  8  constant 8'hF0 at all times, including during reset.

Function
REQ-012 FSM states IDLE, RECORD, PLAY; all transitions require ena=1, and ena=0 holds every register.
REQ-013 IDLE with rec_req=1 SHALL enter RECORD, latch ch_sel, and clear that channel's count and write pointer; rec_req wins if play_req is also 1.
REQ-014 IDLE with play_req=1, rec_req=0 and selected-channel count>0 SHALL enter PLAY with read pointer 0; count=0 keeps IDLE.
REQ-015 RECORD SHALL write ui_in into mem[ch][wptr] every enabled cycle, increment wptr and count, the first write occurring on the entry edge.
REQ-016 RECORD SHALL return to IDLE when count reaches DEPTH (full; no overwrite/wrap) or when rec_req=0, retaining count.
REQ-017 PLAY SHALL present mem[ch][rptr] on uo_out one cycle after rptr is issued (latency 1), incrementing rptr each enabled cycle.
REQ-018 At rptr=count-1: loop_en=1 wraps rptr to 0 seamlessly; otherwise return to IDLE, uo_out holding last sample.
REQ-019 play_req=0 during PLAY SHALL return to IDLE next cycle; rec_req ignored in PLAY; ch_sel changes mid-operation ignored (channel latched).
REQ-020 full = (count==DEPTH), empty = (count==0) for the current ch_sel (live, not latched); recording/playing decode the FSM state.
REQ-021 Counts SHALL be clog2(DEPTH)+1 bits wide; pointers clog2(DEPTH) bits.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, all counts/pointers 0, uo_out=0, uio_out=0; memory contents undefined and unused after reset (counts 0).
REQ-023 Reset asserted mid-RECORD or mid-PLAY SHALL abort the operation with no further writes.

Configuration
REQ-024 Macro GRAVADOR_LOOP_EN defined: loop playback per REQ-018; undefined: uio_in[2] ignored, playback always stops at end, no loop logic synthesised.

Structure
REQ-025 Package gravador_pkg SHALL hold the FSM state enum and uio bit-index constants.
REQ-026 Storage SHALL be sub-module gravador_mem (NCH x DEPTH x SAMPLE_W, one sync write port, one registered read port).

Verification
REQ-027 Record 5 samples 0x11..0x15 on ch0, drop rec_req -> count 5, empty=0, full=0, recording=0.
REQ-028 Play ch0, loop_en=0 -> uo_out 0x11..0x15 on consecutive cycles starting 1 cycle after PLAY entry, then IDLE, uo_out holds 0x15.
REQ-029 Hold rec_req 20 cycles with DEPTH=16 -> exactly 16 writes, full=1, IDLE after 16th write.
REQ-030 Loop play of 3 samples 0xA0,0xA1,0xA2 for 9 cycles (GRAVADOR_LOOP_EN) -> sequence repeats 3 times without gap; without macro -> stops after 0xA2.
REQ-031 rec_req and play_req both 1 in IDLE -> RECORD; play on empty ch1 -> stays IDLE, playing=0.
REQ-032 rst_n low mid-PLAY, ena toggling -> uo_out=0, uio_out=0, uio_oe=0xF0 at once; ena=0 freezes rptr and uo_out.
